// File: rtl/axil_reg_responder.sv
`default_nettype none
// =============================================================================
// Module  : axil_reg_responder
// Brief   : AXI4-Lite slave with NUM_WORDS x 32-bit byte-strobed storage.
//           Optional AXIL_RESP_ADDR_CHECK_EN: out-of-range word index -> SLVERR.
// Rev     : 1.0
// =============================================================================
module axil_reg_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_WORDS          = 16
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);

    localparam int              C_DW     = C_S_AXI_DATA_WIDTH;
    localparam int              C_SW     = C_S_AXI_DATA_WIDTH / 8;
    localparam int              C_AIW    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int              C_IDXW   = $clog2(NUM_WORDS);
    localparam logic [1:0]      C_OKAY   = 2'b00;
    localparam logic [1:0]      C_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_VALID = 1'b1
    } rstate_t;

    wstate_t            r_wstate, w_wstate_nxt;
    rstate_t            r_rstate, w_rstate_nxt;

    logic [C_DW-1:0]    r_mem [NUM_WORDS];
    logic [C_AIW-1:0]   r_awidx;
    logic [C_DW-1:0]    r_wdata;
    logic [C_SW-1:0]    r_wstrb;
    logic [1:0]         r_bresp;
    logic [C_DW-1:0]    r_rdata;
    logic [1:0]         r_rresp;

    logic               w_awready, w_wready, w_arready;
    logic               w_commit;
    logic [C_AIW-1:0]   w_cidx;
    logic [C_DW-1:0]    w_cdata;
    logic [C_SW-1:0]    w_cstrb;
    logic [C_AIW-1:0]   w_awidx, w_aridx;
    logic               w_cin_range, w_rin_range;
    logic               w_cok, w_rok;
    logic               w_unused;

    assign w_awidx  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_aridx  = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0], w_cin_range, w_rin_range};

    // An index is in range when every bit above the storage index is zero.
    generate
        if (C_AIW > C_IDXW) begin : g_range_chk
            assign w_cin_range = (w_cidx[C_AIW-1:C_IDXW] == '0);
            assign w_rin_range = (w_aridx[C_AIW-1:C_IDXW] == '0);
        end else begin : g_range_full
            assign w_cin_range = 1'b1;
            assign w_rin_range = 1'b1;
        end
    endgenerate

`ifdef AXIL_RESP_ADDR_CHECK_EN
    assign w_cok = w_cin_range;
    assign w_rok = w_rin_range;
`else
    assign w_cok = 1'b1;
    assign w_rok = 1'b1;
`endif

    // ---------------------------------------------------------------- write FSM
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // The commit source comes from the live bus for whichever half arrives last.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_commit     = 1'b0;
        w_cidx       = r_awidx;
        w_cdata      = r_wdata;
        w_cstrb      = r_wstrb;
        case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                w_wready  = 1'b1;
                w_cidx    = w_awidx;
                w_cdata   = s00_axi_wdata;
                w_cstrb   = s00_axi_wstrb;
                if (s00_axi_awvalid && s00_axi_wvalid) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else if (s00_axi_awvalid) begin
                    w_wstate_nxt = W_HAVE_A;
                end else if (s00_axi_wvalid) begin
                    w_wstate_nxt = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                w_wready = 1'b1;
                w_cdata  = s00_axi_wdata;
                w_cstrb  = s00_axi_wstrb;
                if (s00_axi_wvalid) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_HAVE_D: begin
                w_awready = 1'b1;
                w_cidx    = w_awidx;
                if (s00_axi_awvalid) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: begin
                w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_awidx <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_bresp <= C_OKAY;
        end else begin
            if (s00_axi_awvalid && w_awready) begin
                r_awidx <= w_awidx;
            end
            if (s00_axi_wvalid && w_wready) begin
                r_wdata <= s00_axi_wdata;
                r_wstrb <= s00_axi_wstrb;
            end
            if (w_commit) begin
                r_bresp <= w_cok ? C_OKAY : C_SLVERR;
            end
        end
    end

    // ------------------------------------------------------------------ storage
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit && w_cok) begin
            for (int b = 0; b < C_SW; b++) begin
                if (w_cstrb[b]) begin
                    r_mem[w_cidx[C_IDXW-1:0]][b*8 +: 8] <= w_cdata[b*8 +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------------- read FSM
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (s00_axi_arvalid) begin
                    w_rstate_nxt = R_VALID;
                end
            end
            R_VALID: begin
                if (s00_axi_rready) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    // Storage is sampled before this edge's commit lands, so a colliding read sees old data.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_rdata <= '0;
            r_rresp <= C_OKAY;
        end else if (s00_axi_arvalid && w_arready) begin
            r_rdata <= w_rok ? r_mem[w_aridx[C_IDXW-1:0]] : '0;
            r_rresp <= w_rok ? C_OKAY : C_SLVERR;
        end
    end

    // ------------------------------------------------------------------ outputs
    assign s00_axi_awready = w_awready & ~s00_axi_areset;
    assign s00_axi_wready  = w_wready & ~s00_axi_areset;
    assign s00_axi_arready = w_arready & ~s00_axi_areset;
    assign s00_axi_bvalid  = (r_wstate == W_RESP) & ~s00_axi_areset;
    assign s00_axi_rvalid  = (r_rstate == R_VALID) & ~s00_axi_areset;
    assign s00_axi_bresp   = s00_axi_areset ? 2'b00 : r_bresp;
    assign s00_axi_rresp   = s00_axi_areset ? 2'b00 : r_rresp;
    assign s00_axi_rdata   = s00_axi_areset ? '0 : r_rdata;

endmodule
`default_nettype wire
